// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with big-endian sub-word load extraction,
// register-file write port, misaligned-load flag and retired-instruction counter.
module mem_wb_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  memValid,
   input  logic [DATA_WIDTH-1:0] aluOutput,
   input  logic [DATA_WIDTH-1:0] memoryData,
   input  logic [REG_ADDR_W-1:0] destinationRegister,
   input  logic                  shouldWriteRegister,
   input  logic                  memToRegister,
   input  logic [2:0]            loadType,
   output logic                  wbValid,
   output logic                  wbRegisterWrite,
   output logic [REG_ADDR_W-1:0] wbDestination,
   output logic [DATA_WIDTH-1:0] wbData,
   output logic                  alignError,
   output logic [CNT_WIDTH-1:0]  retiredCount
);

   localparam logic [2:0] LT_LB  = 3'd1;
   localparam logic [2:0] LT_LBU = 3'd2;
   localparam logic [2:0] LT_LH  = 3'd3;
   localparam logic [2:0] LT_LHU = 3'd4;

   logic [1:0]            addr_lo;
   logic [7:0]            load_byte;
   logic [15:0]           load_half;
   logic [DATA_WIDTH-1:0] load_value;
   logic                  misaligned;

   logic                  valid_q, valid_d;
   logic                  reg_write_q, reg_write_d;
   logic [REG_ADDR_W-1:0] dest_q, dest_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  align_err_q, align_err_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d;

   assign addr_lo = aluOutput[1:0];

   // Big-endian sub-word select and extension; misaligned accesses use the truncated address
   always_comb begin
      case (addr_lo)
         2'd0:    load_byte = memoryData[31:24];
         2'd1:    load_byte = memoryData[23:16];
         2'd2:    load_byte = memoryData[15:8];
         default: load_byte = memoryData[7:0];
      endcase
      load_half  = addr_lo[1] ? memoryData[15:0] : memoryData[31:16];
      load_value = memoryData;
      misaligned = 1'b0;
      case (loadType)
         LT_LB:   load_value = {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};
         LT_LBU:  load_value = {{(DATA_WIDTH-8){1'b0}}, load_byte};
         LT_LH: begin
            load_value = {{(DATA_WIDTH-16){load_half[15]}}, load_half};
            misaligned = addr_lo[0];
         end
         LT_LHU: begin
            load_value = {{(DATA_WIDTH-16){1'b0}}, load_half};
            misaligned = addr_lo[0];
         end
         default: begin
            // LW and the unused encodings 5-7 all behave as a full word
            load_value = memoryData;
            misaligned = (addr_lo != 2'd0);
         end
      endcase
   end

   // Next-state: flush (or an empty MEM slot) loads a bubble, stall holds, otherwise capture
   always_comb begin
      valid_d     = valid_q;
      reg_write_d = reg_write_q;
      dest_d      = dest_q;
      data_d      = data_q;
      align_err_d = 1'b0;
      count_d     = count_q;
      if (flush || (!stall && !memValid)) begin
         valid_d     = 1'b0;
         reg_write_d = 1'b0;
         dest_d      = '0;
         data_d      = '0;
      end else if (!stall) begin
         valid_d     = 1'b1;
         reg_write_d = shouldWriteRegister && (destinationRegister != '0);
         dest_d      = destinationRegister;
         data_d      = memToRegister ? load_value : aluOutput;
         align_err_d = memToRegister && misaligned;
         count_d     = count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   // Pipeline state; reset clears everything including the retire counter
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
         dest_q      <= '0;
         data_q      <= '0;
         align_err_q <= 1'b0;
         count_q     <= '0;
      end else begin
         valid_q     <= valid_d;
         reg_write_q <= reg_write_d;
         dest_q      <= dest_d;
         data_q      <= data_d;
         align_err_q <= align_err_d;
         count_q     <= count_d;
      end
   end

   assign wbValid         = valid_q;
   assign wbRegisterWrite = reg_write_q;
   assign wbDestination   = dest_q;
   assign wbData          = data_q;
   assign alignError      = align_err_q;
   assign retiredCount    = count_q;

endmodule
